arc4_encrypt: RTL
=================

// Module: arc4_encrypt
// PURPOSE
// - ARC4 encryptor: writer-side counterpart of the ct-memory consumer used by the key-crack top (task4).
// - Reads a length-prefixed plaintext from pt memory and runs init, KSA and PRGA on an external
//   256x8 S memory. Writes a length-prefixed ciphertext into ct memory in the same format the
//   cracker reads: ct[0]=len, ct[1..len]=data.
// - Sits beside the existing arc4 decrypt/crack path. Its output is directly loadable as the crack target.
// PARAMETERS
// - KEY_W  24  key width in bits; key byte k = key[KEY_W-1-8*(k%3) -: 8] (MSB byte first)
// - LEN_W   8  width of the length prefix / message addresses
// PORTS
// - clk         in   1   rising-edge clock
// - rst         in   1   synchronous, active-high reset
// - en          in   1   start request; sampled only while rdy=1
// - rdy         out  1   1 = idle and able to accept en
// - key         in   24  secret key, latched on the accepted en cycle
// - s_addr      out  8   S memory address
// - s_rddata    in   8   S read data, valid 1 cycle after s_addr (registered-address RAM)
// - s_wrdata    out  8   S write data
// - s_wren      out  1   S write enable
// - pt_addr     out  8   plaintext memory address
// - pt_rddata   in   8   plaintext read data, 1-cycle latency
// - ct_addr     out  8   ciphertext memory address
// - ct_wrdata   out  8   ciphertext write data
// - ct_wren     out  1   ciphertext write enable
// BEHAVIOUR
// - Reset: rdy=1; s_wren=ct_wren=0; all addresses and wrdata 0; i=j=0; state IDLE.
// - Reset mid-operation: state returns to IDLE on the next edge and all wren drop the same edge.
//   Memory writes already done are not undone.
// - Handshake: en && rdy -> latch key, rdy=0 next cycle. en while rdy=0 is ignored.
//   rdy returns to 1 the cycle after the last ct write. A new en is accepted that same cycle.
// - INIT: i=0..255, S[i]=i, one write per cycle (256 cycles).
// - KSA: for i=0..255, j=(j+S[i]+key_byte(i%3)) mod 256, swap S[i],S[j].
//   - Sub-states: RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J.
//   - All sums are 8-bit and wrap mod 256 by truncation.
//   - i==j: both writes occur and S is unchanged.
// - LEN: read pt[0] (2 cycles), hold it as len, write ct[0]=len.
// - PRGA: i=j=0; for k=1..len:
//   - i=i+1; j=j+S[i]; swap S[i],S[j]; pad=S[(S[i]+S[j]) mod 256].
//   - ct[k]=pt[k]^pad.
//   - pt[k] read overlaps the S reads.
//   - Exactly one ct write per k, in increasing k order.
// - len=0: ct[0]=0 is the only ct write; PRGA is skipped; rdy rises next cycle.
// - len=255: k and ct_addr end at 255 with no wrap. Total ct writes = len+1.
// - Mutual exclusion: at most one of s_wren/ct_wren per cycle. pt is never written.
// - Latency budget: at most 256 + 6*256 + 3 + 10*len cycles from en accept to rdy.
// STRUCTURE
// - arc4_pkg (shared with decrypt/crack):
//   - state enum t_arc4_state
//   - KEY_BYTES=3
//   - function key_byte(key,i)
// - Single FSM plus datapath registers (i, j, si, sj, len, k, key_q).
// - No sub-module. The swap sequence is inlined so that S-port ownership stays in one always_ff.
// TESTING
// - Reset during KSA (en at t0, rst pulse at t0+500 cycles) -> rdy=1 and no wren next cycle.
//   A fresh en then completes normally.
// - key=24'h000018, len=0 -> exactly one ct write (ct[0]=8'h00). rdy rises 1 cycle later.
//   S ends equal to the software KSA state.
// - key=24'h1E4600, pt=len 5 "hello" -> ct bytes match the C/Python ARC4 model byte-for-byte.
//   Feeding ct to the existing arc4 decryptor returns "hello".
// - pt all 8'h00, len=255 -> ct[1..255] equals the model keystream. The last write is at ct_addr=255.
//   No write to ct_addr 0 after the prefix.
// - Back-to-back: en held high across completion with 2nd key 24'hFFFFFF.
//   - 2nd run starts on the rdy cycle.
//   - ct is overwritten with the 2nd ciphertext.
//   - The bench counts exactly len+1 ct writes per run.
// - Protocol assertions throughout: no en acceptance while rdy=0; never s_wren&&ct_wren.

Source files
------------

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared ARC4 FSM state encoding, key geometry and key-byte selection
// contents: KEY_W/KEY_BYTES key geometry, t_arc4_state, key_byte(key, i) -> key byte for index i
package arc4_pkg;
    localparam int KEY_W     = 24;
    localparam int KEY_BYTES = 3;

    typedef enum logic [4:0] {
        IDLE, INIT,
        RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J,
        LEN,
        P_RD_I, P_WAIT_I, P_RD_J, P_WAIT_J, P_WR_I, P_WR_J, P_RD_P, P_WAIT_P, P_CT,
        FIN
    } t_arc4_state;

    // MSB byte of the key is used for i%3 == 0
    function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] key, input logic [7:0] i);
        logic [7:0] m;
        m = i % 8'(KEY_BYTES);
        return key[KEY_W-1-8*int'(m) -: 8];
    endfunction
endpackage

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 encryptor producing a length-prefixed ciphertext (ct[0]=len, ct[1..len]=data)
// ports: clk, rst (sync, active-high); en/rdy start handshake, key latched on accept;
//        s_addr/s_rddata/s_wrdata/s_wren drive an external 256x8 S RAM (1-cycle read latency);
//        pt_addr/pt_rddata read the plaintext (1-cycle latency); ct_addr/ct_wrdata/ct_wren write ciphertext
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key,
    output logic [7:0]       s_addr,
    input  logic [7:0]       s_rddata,
    output logic [7:0]       s_wrdata,
    output logic             s_wren,
    output logic [LEN_W-1:0] pt_addr,
    input  logic [7:0]       pt_rddata,
    output logic [LEN_W-1:0] ct_addr,
    output logic [7:0]       ct_wrdata,
    output logic             ct_wren
);
    t_arc4_state      state_q, state_d;
    logic [7:0]       i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [LEN_W-1:0] len_q, len_d, k_q, k_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             rdy_q, rdy_d, s_wren_q, s_wren_d, ct_wren_q, ct_wren_d;
    logic [7:0]       s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d, ct_wrdata_q, ct_wrdata_d;
    logic [LEN_W-1:0] pt_addr_q, pt_addr_d, ct_addr_q, ct_addr_d;

    // Outputs are registered: a write decided in state X appears on the bus during the next state.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        len_d       = len_q;
        k_d         = k_q;
        key_d       = key_q;
        rdy_d       = rdy_q;
        s_addr_d    = s_addr_q;
        s_wrdata_d  = s_wrdata_q;
        pt_addr_d   = pt_addr_q;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        s_wren_d    = 1'b0;
        ct_wren_d   = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                key_d     = key;
                rdy_d     = 1'b0;
                i_d       = 8'd0;
                j_d       = 8'd0;
                pt_addr_d = '0;  // pt[0] is then stable by the time LEN samples it
                state_d   = INIT;
            end
            INIT: begin
                s_addr_d   = i_q;
                s_wrdata_d = i_q;
                s_wren_d   = 1'b1;
                i_d        = i_q + 8'd1;
                state_d    = (i_q == 8'hFF) ? RD_I : INIT;
            end
            RD_I: begin
                s_addr_d = i_q;
                state_d  = WAIT_I;
            end
            WAIT_I:   state_d = RD_J;
            RD_J: begin
                si_d     = s_rddata;
                j_d      = j_q + s_rddata + key_byte(key_q, i_q);
                s_addr_d = j_d;
                state_d  = WAIT_J;
            end
            WAIT_J:   state_d = WR_I;
            WR_I, P_WR_I: begin
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
                state_d    = (state_q == WR_I) ? WR_J : P_WR_J;
            end
            WR_J: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
                i_d        = i_q + 8'd1;
                state_d    = (i_q == 8'hFF) ? LEN : RD_I;
            end
            LEN: begin
                len_d       = LEN_W'(pt_rddata);
                ct_addr_d   = '0;
                ct_wrdata_d = pt_rddata;
                ct_wren_d   = 1'b1;
                i_d         = 8'd0;
                j_d         = 8'd0;
                k_d         = LEN_W'(1);
                state_d     = (pt_rddata == 8'd0) ? FIN : P_RD_I;
            end
            P_RD_I: begin
                i_d       = i_q + 8'd1;
                s_addr_d  = i_q + 8'd1;
                pt_addr_d = k_q;  // pt[k] fetch overlaps the S reads
                state_d   = P_WAIT_I;
            end
            P_WAIT_I: state_d = P_RD_J;
            P_RD_J: begin
                si_d     = s_rddata;
                j_d      = j_q + s_rddata;
                s_addr_d = j_d;
                state_d  = P_WAIT_J;
            end
            P_WAIT_J: state_d = P_WR_I;
            P_WR_J: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
                state_d    = P_RD_P;
            end
            P_RD_P: begin
                s_addr_d = si_q + sj_q;
                state_d  = P_WAIT_P;
            end
            P_WAIT_P: state_d = P_CT;
            P_CT: begin
                ct_addr_d   = k_q;
                ct_wrdata_d = pt_rddata ^ s_rddata;
                ct_wren_d   = 1'b1;
                k_d         = k_q + LEN_W'(1);
                state_d     = (k_q == len_q) ? FIN : P_RD_I;
            end
            FIN: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            len_q       <= '0;
            k_q         <= '0;
            key_q       <= '0;
            rdy_q       <= 1'b1;
            s_addr_q    <= '0;
            s_wrdata_q  <= '0;
            s_wren_q    <= 1'b0;
            pt_addr_q   <= '0;
            ct_addr_q   <= '0;
            ct_wrdata_q <= '0;
            ct_wren_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            len_q       <= len_d;
            k_q         <= k_d;
            key_q       <= key_d;
            rdy_q       <= rdy_d;
            s_addr_q    <= s_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            s_wren_q    <= s_wren_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
        end
    end

    assign rdy       = rdy_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;
endmodule
